// File: rtl/sprite_comp_pkg.sv
// Shared types and reset-time background band table for the sprite compositor.
// Colours are packed {r, g, b}, one CHANW-wide channel each.
package sprite_comp_pkg;

    localparam int SC_CORDW = 16;
    localparam int SC_CHANW = 4;
    localparam int COLRW    = 3 * SC_CHANW;
    localparam int SC_BANDS = 8;

    typedef logic [COLRW-1:0] colr_t;

    typedef struct packed {
        logic [SC_CORDW-1:0] start;
        colr_t               colr;
    } band_t;

    localparam band_t BG_DEFAULT [SC_BANDS] = '{
        '{start: 16'd0,   colr: 12'h239},
        '{start: 16'd120, colr: 12'h24A},
        '{start: 16'd220, colr: 12'h25B},
        '{start: 16'd300, colr: 12'h26C},
        '{start: 16'd360, colr: 12'h27D},
        '{start: 16'd410, colr: 12'h29E},
        '{start: 16'd450, colr: 12'h2BF},
        '{start: 16'd480, colr: 12'h260}
    };

endpackage

// File: rtl/sprite_compositor_delay_line.sv
// Fixed-depth shift register used to align per-pixel flags with the CLUT output.
// Every stage clears on reset so stale pixels never reach the output after a reset.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_reg [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] stage_in;

        if (gi == 0) begin : g_first
            assign stage_in = d;
        end else begin : g_rest
            assign stage_in = stage_reg[gi-1];
        end

        always_ff @(posedge clk_pix or posedge rst_pix) begin
            if (rst_pix) begin
                stage_reg[gi] <= '0;
            end else begin
                stage_reg[gi] <= stage_in;
            end
        end
    end

    assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/sprite_compositor.sv
// Merges indexed sprite layers over a banded background, blanks outside de, registers
// colour/sync for DVI and flags sprite-to-sprite collisions per pixel and per frame.
module sprite_compositor
    import sprite_comp_pkg::*;
#(
    parameter int               CORDW      = 16,
    parameter int               CHANW      = 4,
    parameter int               CIDXW      = 4,
    parameter int               NSPR       = 2,
    parameter logic [CIDXW-1:0] TRANS_INDX = 'h9,
    parameter int               CLUT_LAT   = 1,
    parameter int               BG_BANDS   = 8
) (
    input  logic                          clk_pix,
    input  logic                          rst_pix,
    input  logic                          line,
    input  logic                          frame,
    input  logic [CORDW-1:0]              sy,
    input  logic                          de,
    input  logic                          hsync,
    input  logic                          vsync,
    input  logic [NSPR-1:0]               spr_drawing,
    input  logic [NSPR*CIDXW-1:0]         spr_indx,
    input  logic [NSPR*3*CHANW-1:0]       spr_colr,
    input  logic                          bg_we,
    input  logic [$clog2(BG_BANDS)-1:0]   bg_addr,
    input  logic [CORDW-1:0]              bg_start,
    input  logic [3*CHANW-1:0]            bg_colr_in,
    output logic [2*CHANW-1:0]            dvi_r,
    output logic [2*CHANW-1:0]            dvi_g,
    output logic [2*CHANW-1:0]            dvi_b,
    output logic                          dvi_de,
    output logic                          dvi_hsync,
    output logic                          dvi_vsync,
    output logic                          collide,
    output logic                          collide_frm
);

    localparam int CW = 3 * CHANW;

    logic [NSPR-1:0]  opaque;
    logic [NSPR-1:0]  opaque_d;
    logic [2:0]       sync_d;
    logic             de_d;
    logic             hsync_d;
    logic             vsync_d;
    logic [CORDW-1:0] band_start [BG_BANDS];
    logic [CW-1:0]    band_colr  [BG_BANDS];
    logic [CW-1:0]    bg_colr_reg;
    logic [CW-1:0]    bg_colr_next;
    logic [CW-1:0]    sel_colr;
    int               n_opaque;
    logic             sticky_reg;

    for (genvar gi = 0; gi < NSPR; gi++) begin : g_opaque
        assign opaque[gi] = spr_drawing[gi] && (spr_indx[gi*CIDXW +: CIDXW] != TRANS_INDX);
    end

    delay_line #(.WIDTH(NSPR), .DEPTH(CLUT_LAT)) u_opaque_dly (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .d       (opaque),
        .q       (opaque_d)
    );

    delay_line #(.WIDTH(3), .DEPTH(CLUT_LAT)) u_sync_dly (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .d       ({de, hsync, vsync}),
        .q       (sync_d)
    );

    assign de_d    = sync_d[2];
    assign hsync_d = sync_d[1];
    assign vsync_d = sync_d[0];

    // One register pair per band; entries past the default table start unmatched.
    for (genvar gi = 0; gi < BG_BANDS; gi++) begin : g_band
        logic [CORDW-1:0] start_reg;
        logic [CW-1:0]    colr_reg;

        always_ff @(posedge clk_pix or posedge rst_pix) begin
            if (rst_pix) begin
                if (gi < SC_BANDS) begin
                    start_reg <= CORDW'(BG_DEFAULT[gi].start);
                    colr_reg  <= CW'(BG_DEFAULT[gi].colr);
                end else begin
                    start_reg <= '1;
                    colr_reg  <= '0;
                end
            end else if (bg_we && (32'(bg_addr) == gi)) begin
                start_reg <= bg_start;
                colr_reg  <= bg_colr_in;
            end
        end

        assign band_start[gi] = start_reg;
        assign band_colr[gi]  = colr_reg;
    end

    // Descending scan so the lowest matching entry wins; a write in the same cycle is not yet visible.
    always_comb begin
        bg_colr_next = bg_colr_reg;
        for (int i = BG_BANDS - 1; i >= 0; i--) begin
            if (band_start[i] == sy) begin
                bg_colr_next = band_colr[i];
            end
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            bg_colr_reg <= CW'(BG_DEFAULT[0].colr);
        end else if (line) begin
            bg_colr_reg <= bg_colr_next;
        end
    end

    always_comb begin
        sel_colr = bg_colr_reg;
        n_opaque = 0;
        for (int i = NSPR - 1; i >= 0; i--) begin
            if (opaque_d[i]) begin
                sel_colr = spr_colr[i*CW +: CW];
                n_opaque = n_opaque + 1;
            end
        end
        if (!de_d) begin
            sel_colr = '0;
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            dvi_r       <= '0;
            dvi_g       <= '0;
            dvi_b       <= '0;
            dvi_de      <= 1'b0;
            dvi_hsync   <= 1'b0;
            dvi_vsync   <= 1'b0;
            collide     <= 1'b0;
            collide_frm <= 1'b0;
            sticky_reg  <= 1'b0;
        end else begin
            dvi_r     <= {2{sel_colr[CW-1 -: CHANW]}};
            dvi_g     <= {2{sel_colr[2*CHANW-1 -: CHANW]}};
            dvi_b     <= {2{sel_colr[CHANW-1:0]}};
            dvi_de    <= de_d;
            dvi_hsync <= hsync_d;
            dvi_vsync <= vsync_d;
            collide   <= de_d && (n_opaque >= 2);
            // A collision on the pixel that coincides with the frame strobe still counts for the ending frame.
            if (frame) begin
                collide_frm <= sticky_reg | collide;
                sticky_reg  <= 1'b0;
            end else if (collide) begin
                sticky_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: a cycle model predicts every output each cycle,
// and literal checks pin the model at the interesting points of each scenario.
module tb_sprite_compositor;

    localparam int LAT   = 1;
    localparam int NSPR  = 2;
    localparam int CIDXW = 4;

    localparam logic [15:0] DEF_S [8] = '{16'd0, 16'd120, 16'd220, 16'd300,
                                          16'd360, 16'd410, 16'd450, 16'd480};
    localparam logic [11:0] DEF_C [8] = '{12'h239, 12'h24A, 12'h25B, 12'h26C,
                                          12'h27D, 12'h29E, 12'h2BF, 12'h260};

    logic        clk_pix = 1'b0;
    logic        rst_pix = 1'b1;
    logic        line = 1'b0;
    logic        frame = 1'b0;
    logic [15:0] sy = '0;
    logic        de = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic [1:0]  spr_drawing = '0;
    logic [7:0]  spr_indx = '0;
    logic [23:0] spr_colr;
    logic        bg_we = 1'b0;
    logic [2:0]  bg_addr = '0;
    logic [15:0] bg_start = '0;
    logic [11:0] bg_colr_in = '0;
    logic [7:0]  dvi_r, dvi_g, dvi_b;
    logic        dvi_de, dvi_hsync, dvi_vsync, collide, collide_frm;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_pix = ~clk_pix;

    sprite_compositor #(.CLUT_LAT(LAT)) dut (
        .clk_pix     (clk_pix),
        .rst_pix     (rst_pix),
        .line        (line),
        .frame       (frame),
        .sy          (sy),
        .de          (de),
        .hsync       (hsync),
        .vsync       (vsync),
        .spr_drawing (spr_drawing),
        .spr_indx    (spr_indx),
        .spr_colr    (spr_colr),
        .bg_we       (bg_we),
        .bg_addr     (bg_addr),
        .bg_start    (bg_start),
        .bg_colr_in  (bg_colr_in),
        .dvi_r       (dvi_r),
        .dvi_g       (dvi_g),
        .dvi_b       (dvi_b),
        .dvi_de      (dvi_de),
        .dvi_hsync   (dvi_hsync),
        .dvi_vsync   (dvi_vsync),
        .collide     (collide),
        .collide_frm (collide_frm)
    );

    function automatic logic [11:0] clut(int layer, logic [3:0] idx);
        if (layer == 0 && idx == 4'd3) return 12'hF00;
        if (layer == 1 && idx == 4'd5) return 12'h0F0;
        return {idx, 4'(layer) + 4'h4, ~idx};
    endfunction

    // CLUT stand-in: colour appears LAT cycles after the index.
    logic [23:0] clut_pipe [LAT];
    always @(posedge clk_pix) begin
        clut_pipe[0] <= {clut(1, spr_indx[7:4]), clut(0, spr_indx[3:0])};
        for (int k = 1; k < LAT; k++) clut_pipe[k] <= clut_pipe[k-1];
    end
    assign spr_colr = clut_pipe[LAT-1];

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [1:0] drw;
        logic [7:0] idx;
        logic       de;
        logic       hs;
        logic       vs;
    } in_t;

    in_t         hist [LAT];
    logic [15:0] m_start [8];
    logic [11:0] m_colr  [8];
    logic [11:0] m_bg;
    logic        m_sticky;
    logic [11:0] e_colr;
    logic        e_de, e_hs, e_vs, e_col, e_frm;

    function automatic logic is_opaque(in_t o, int i);
        return o.drw[i] && (o.idx[i*CIDXW +: CIDXW] != 4'h9);
    endfunction

    function automatic logic [11:0] pixel_colr(in_t o, logic [11:0] bg);
        if (!o.de) return 12'h000;
        for (int i = 0; i < NSPR; i++)
            if (is_opaque(o, i)) return clut(i, o.idx[i*CIDXW +: CIDXW]);
        return bg;
    endfunction

    function automatic logic collides(in_t o);
        int n = 0;
        for (int i = 0; i < NSPR; i++) if (is_opaque(o, i)) n++;
        return o.de && (n >= 2);
    endfunction

    function automatic logic [11:0] band_of(logic [15:0] y, logic [11:0] cur);
        for (int i = 0; i < 8; i++) if (m_start[i] == y) return m_colr[i];
        return cur;
    endfunction

    always @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            for (int k = 0; k < LAT; k++) hist[k] <= '0;
            for (int i = 0; i < 8; i++) begin
                m_start[i] <= DEF_S[i];
                m_colr[i]  <= DEF_C[i];
            end
            m_bg     <= 12'h239;
            m_sticky <= 1'b0;
            e_colr   <= '0;
            e_de     <= 1'b0;
            e_hs     <= 1'b0;
            e_vs     <= 1'b0;
            e_col    <= 1'b0;
            e_frm    <= 1'b0;
        end else begin
            e_colr <= pixel_colr(hist[LAT-1], m_bg);
            e_de   <= hist[LAT-1].de;
            e_hs   <= hist[LAT-1].hs;
            e_vs   <= hist[LAT-1].vs;
            e_col  <= collides(hist[LAT-1]);
            if (frame) begin
                e_frm    <= m_sticky | e_col;
                m_sticky <= 1'b0;
            end else if (e_col) begin
                m_sticky <= 1'b1;
            end
            if (line) m_bg <= band_of(sy, m_bg);
            if (bg_we) begin
                m_start[bg_addr] <= bg_start;
                m_colr[bg_addr]  <= bg_colr_in;
            end
            hist[0] <= {spr_drawing, spr_indx, de, hsync, vsync};
            for (int k = 1; k < LAT; k++) hist[k] <= hist[k-1];
        end
    end

    logic [28:0] exp_bus, act_bus;
    always @(negedge clk_pix) begin
        exp_bus = {{2{e_colr[11:8]}}, {2{e_colr[7:4]}}, {2{e_colr[3:0]}},
                   e_de, e_hs, e_vs, e_col, e_frm};
        act_bus = {dvi_r, dvi_g, dvi_b, dvi_de, dvi_hsync, dvi_vsync, collide, collide_frm};
        n_total++;
        if (act_bus !== exp_bus) begin
            n_bad++;
            $display("FAIL model_cycle t=%0t got rgb=%h de/hs/vs/col/frm=%b want rgb=%h de/hs/vs/col/frm=%b",
                     $time, act_bus[28:5], act_bus[4:0], exp_bus[28:5], exp_bus[4:0]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk_pix);
        #2;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic do_line(logic [15:0] y);
        line = 1'b1;
        sy   = y;
        cyc();
        line = 1'b0;
    endtask

    task automatic do_frame();
        frame = 1'b1;
        cyc();
        frame = 1'b0;
    endtask

    int ncol;

    initial begin
        repeat (3) cyc();
        rst_pix = 1'b0;

        // Reset mid-line
        do_line(16'd0);
        de = 1'b1; spr_drawing = 2'b01; spr_indx = 8'h03;
        repeat (4) cyc();
        check("pre_reset_r", 32'(dvi_r), 32'hFF);
        rst_pix = 1'b1;
        #1;
        check("reset_async_rgb", 32'({dvi_r, dvi_g, dvi_b}), 32'h0);
        check("reset_async_de", 32'(dvi_de), 32'h0);
        repeat (3) cyc();
        check("reset_hold_all", 32'({dvi_r, dvi_g, dvi_b, dvi_de, collide, collide_frm}), 32'h0);
        rst_pix = 1'b0;
        spr_drawing = 2'b00;
        do_line(16'd0);
        repeat (LAT + 1) cyc();
        check("bg_default_rgb", 32'({dvi_r, dvi_g, dvi_b}), 32'h223399);

        // Latency of sync and colour
        hsync = 1'b1;
        cyc();
        hsync = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            check("hsync_early", 32'(dvi_hsync), 32'h0);
            cyc();
        end
        check("hsync_at_lat", 32'(dvi_hsync), 32'h1);
        check("colr_at_lat_r", 32'(dvi_r), 32'h22);
        cyc();
        check("hsync_after", 32'(dvi_hsync), 32'h0);

        // Priority and transparency
        spr_drawing = 2'b11; spr_indx = 8'h53;
        repeat (LAT + 2) cyc();
        check("prio_l0_rg", 32'({dvi_r, dvi_g}), 32'hFF00);
        spr_indx = 8'h59;
        repeat (LAT + 2) cyc();
        check("prio_fall_rg", 32'({dvi_r, dvi_g}), 32'h00FF);
        spr_indx = 8'h99;
        repeat (LAT + 2) cyc();
        check("prio_both_trans_rgb", 32'({dvi_r, dvi_g, dvi_b}), 32'h223399);
        check("prio_both_trans_col", 32'(collide), 32'h0);

        // Frame flag: previous priority phase collided, then a clean frame
        spr_drawing = 2'b00;
        do_frame();
        check("frm_after_prio", 32'(collide_frm), 32'h1);
        do_frame();
        check("frm_clean", 32'(collide_frm), 32'h0);

        // Four-pixel collision
        ncol = 0;
        spr_indx = 8'h53;
        for (int i = 0; i < 12; i++) begin
            spr_drawing = (i < 4) ? 2'b11 : 2'b00;
            cyc();
            if (collide) ncol++;
        end
        check("collide_cycles", 32'(ncol), 32'd4);
        do_frame();
        check("frm_set", 32'(collide_frm), 32'h1);
        repeat (4) cyc();
        do_frame();
        check("frm_clear", 32'(collide_frm), 32'h0);

        // Band write coincident with line uses the old entry
        bg_we = 1'b1; bg_addr = 3'd2; bg_start = 16'd220; bg_colr_in = 12'hABC;
        line = 1'b1; sy = 16'd220;
        cyc();
        bg_we = 1'b0; line = 1'b0;
        repeat (LAT + 2) cyc();
        check("band_old_entry", 32'({dvi_r, dvi_g, dvi_b}), 32'h2255BB);
        do_frame();
        do_line(16'd220);
        repeat (LAT + 2) cyc();
        check("band_new_entry", 32'({dvi_r, dvi_g, dvi_b}), 32'hAABBCC);
        do_line(16'd7);
        repeat (LAT + 2) cyc();
        check("band_no_match_hold", 32'({dvi_r, dvi_g, dvi_b}), 32'hAABBCC);
        // Full-width start: only an exact 16-bit match selects the band
        bg_we = 1'b1; bg_addr = 3'd3; bg_start = 16'h812C; bg_colr_in = 12'h5A5;
        cyc();
        bg_we = 1'b0;
        do_line(16'd300);
        repeat (LAT + 2) cyc();
        check("band_wide_nomatch", 32'({dvi_r, dvi_g, dvi_b}), 32'hAABBCC);
        do_line(16'h812C);
        repeat (LAT + 2) cyc();
        check("band_wide_match", 32'({dvi_r, dvi_g, dvi_b}), 32'h55AA55);

        // Blanking
        de = 1'b0; spr_drawing = 2'b11; spr_indx = 8'h53;
        repeat (LAT + 2) cyc();
        check("blank_rgb", 32'({dvi_r, dvi_g, dvi_b}), 32'h0);
        check("blank_collide", 32'(collide), 32'h0);
        de = 1'b1;
        repeat (LAT + 2) cyc();
        check("unblank_collide", 32'(collide), 32'h1);
        spr_drawing = 2'b00;
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
